// File: rtl/round_robin_dispatch_if.sv
// Stream bundle for the 1-to-REQ_NUM packet dispatcher: one input stream,
// REQ_NUM output streams, per-output enables and a packet-busy flag.
interface round_robin_dispatch_if #(
    parameter int REQ_NUM = 8
);
    logic               valid_in;
    logic               data_in;
    logic               last_in;
    logic               ready_in;
    logic [REQ_NUM-1:0] dst_en;
    logic [REQ_NUM-1:0] valid_out;
    logic [REQ_NUM-1:0] data_out;
    logic [REQ_NUM-1:0] last_out;
    logic [REQ_NUM-1:0] ready_out;
    logic               busy;

    modport master (
        output valid_in, data_in, last_in, dst_en, ready_out,
        input  ready_in, valid_out, data_out, last_out, busy
    );

    modport slave (
        input  valid_in, data_in, last_in, dst_en, ready_out,
        output ready_in, valid_out, data_out, last_out, busy
    );
endinterface

// File: rtl/round_robin_dispatch.sv
// Packet-level round-robin distributor: whole packets from one stream are
// spread over REQ_NUM outputs in rotating order through one output register.
module round_robin_dispatch #(
    parameter int REQ_NUM = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    round_robin_dispatch_if.slave    bus
);
    localparam int IDX_W = $clog2(REQ_NUM);

    logic             in_pkt_reg;
    logic [IDX_W-1:0] cur_dst_reg;
    logic [IDX_W-1:0] ptr_reg;
    logic             obuf_v_reg;
    logic             obuf_d_reg;
    logic             obuf_l_reg;
    logic [IDX_W-1:0] obuf_dst_reg;

    logic [IDX_W:0]   sum_w    [REQ_NUM];
    logic [IDX_W-1:0] cand_idx [REQ_NUM];
    logic [REQ_NUM-1:0] cand_hit;
    logic [IDX_W-1:0] nxt_idx;
    logic             any_en;
    logic             accept;
    logic             drain;

    // Candidate gi is the port gi+1 places after ptr, wrapped; ptr itself is last.
    genvar gi;
    generate
        for (gi = 0; gi < REQ_NUM; gi++) begin : g_cand
            assign sum_w[gi]    = {1'b0, ptr_reg} + (IDX_W+1)'(gi + 1);
            assign cand_idx[gi] = (sum_w[gi] >= (IDX_W+1)'(REQ_NUM))
                                ? IDX_W'(sum_w[gi] - (IDX_W+1)'(REQ_NUM))
                                : sum_w[gi][IDX_W-1:0];
            assign cand_hit[gi] = bus.dst_en[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        nxt_idx = ptr_reg;
        for (int k = REQ_NUM - 1; k >= 0; k--) begin
            if (cand_hit[k]) nxt_idx = cand_idx[k];
        end
    end

    assign any_en       = |bus.dst_en;
    assign drain        = obuf_v_reg && bus.ready_out[obuf_dst_reg];
    assign bus.ready_in = (in_pkt_reg || any_en) && (!obuf_v_reg || bus.ready_out[obuf_dst_reg]);
    assign accept       = bus.valid_in && bus.ready_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_pkt_reg   <= 1'b0;
            cur_dst_reg  <= '0;
            ptr_reg      <= IDX_W'(REQ_NUM - 1);
            obuf_v_reg   <= 1'b0;
            obuf_d_reg   <= 1'b0;
            obuf_l_reg   <= 1'b0;
            obuf_dst_reg <= '0;
        end else if (accept) begin
            obuf_v_reg   <= 1'b1;
            obuf_d_reg   <= bus.data_in;
            obuf_l_reg   <= bus.last_in;
            obuf_dst_reg <= in_pkt_reg ? cur_dst_reg : nxt_idx;
            if (!in_pkt_reg) begin
                cur_dst_reg <= nxt_idx;
                ptr_reg     <= nxt_idx;
            end
            // A single-beat packet opens and closes in the same cycle.
            in_pkt_reg <= !bus.last_in;
        end else if (drain) begin
            obuf_v_reg <= 1'b0;
        end
    end

    generate
        for (gi = 0; gi < REQ_NUM; gi++) begin : g_out
            assign bus.valid_out[gi] = obuf_v_reg && (obuf_dst_reg == IDX_W'(gi));
            assign bus.data_out[gi]  = bus.valid_out[gi] && obuf_d_reg;
            assign bus.last_out[gi]  = bus.valid_out[gi] && obuf_l_reg;
        end
    endgenerate

    assign bus.busy = in_pkt_reg;
endmodule

// File: doc/round_robin_dispatch.md
Name: round_robin_dispatch

Overview:
- Packet-level round-robin distributor: takes one valid/ready stream (1-bit data, last marks end of packet) and spreads whole packets across REQ_NUM output streams in rotating order.
- Counterpart of the N-to-1 round-robin packet merger. Sits on the fan-out side of the same stream interface.
- One registered output stage; full throughput (1 beat/cycle) when the selected output is ready.

Parameters:
- REQ_NUM, 8, number of output streams (>=2).
- IDX_W, $clog2(REQ_NUM), width of destination index (derived; not to be overridden).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- valid_in  input  1  input beat valid
- data_in  input  1  input beat data
- last_in  input  1  final beat of packet
- ready_in  output  1  input beat accepted when valid_in & ready_in
- dst_en  input  REQ_NUM  per-output enable; disabled outputs skipped at packet start
- valid_out  output  REQ_NUM  per-output beat valid (one-hot or zero)
- data_out  output  REQ_NUM  per-output data (only bit of selected output meaningful; others 0)
- last_out  output  REQ_NUM  per-output last (only selected bit may be 1)
- ready_out  input  REQ_NUM  per-output ready
- busy  output  1  high while inside a packet (first beat accepted, last not yet accepted)

Behaviour:
- Reset (async, rst_n=0): valid_out=0, data_out=0, last_out=0, busy=0, in_pkt=0, ptr=REQ_NUM-1 (so first packet targets port 0), output buffer empty.
- Registers: in_pkt, cur_dst[IDX_W], ptr[IDX_W] (last destination used), obuf_v, obuf_d, obuf_l, obuf_dst.
- Destination select at packet start (in_pkt=0): nxt = first index i with dst_en[i]=1 scanning ptr+1, ptr+2, ... wrapping modulo REQ_NUM. ptr itself is the last candidate.
- If in_pkt=0 and dst_en=0 (all disabled): ready_in=0 and no beat accepted.
- Otherwise ready_in = !obuf_v | ready_out[obuf_dst]. This is the pipeline-register rule and has no dependency on valid_in.
- On accept (valid_in & ready_in):
  - The beat loads obuf with dst = (in_pkt ? cur_dst : nxt).
  - On the first beat: cur_dst<=nxt, ptr<=nxt, in_pkt<=1.
  - If last_in=1: in_pkt<=0. A single-beat packet sets and clears in the same cycle, so in_pkt stays 0 and ptr still advances.
- Outputs driven from obuf: valid_out = obuf_v ? onehot(obuf_dst) : 0. data_out/last_out are likewise masked to the obuf_dst bit.
- Drain: when obuf_v & ready_out[obuf_dst] and no new accept, obuf_v<=0. Simultaneous drain and accept reloads obuf in the same cycle (no bubble).
- Latency: 1 cycle from input accept to valid_out.
- busy = in_pkt.
- dst_en is sampled only when choosing at packet start. Changes mid-packet do not redirect the current packet, even if cur_dst becomes disabled.
- ready_out of non-selected ports is ignored. Unselected ready_out high has no effect.
- valid_in low mid-packet: stream idles and in_pkt is held. Gaps are allowed between and within packets.
- Reset mid-packet: all state cleared; the partial packet is dropped and the next beat is treated as a packet start to port 0 (first enabled from 0).
- Outputs are AXI-stream style: once valid_out[i] is asserted, data/last are stable until ready_out[i]. This follows from obuf holding.

Test Plan:
- Six 3-beat packets, all dst_en=1, all ready_out=1 -> packets appear on ports 0,1,2,3,4,5 in order. Each beat 1 cycle after input accept. ready_in stays 1; no bubbles.
- dst_en=8'b1010_0101, five 1-beat packets (last_in=1 every beat) -> destinations 0,2,5,7,0. busy stays 0.
- Packet to port 1, ready_out[1]=0 for 4 cycles after the first beat -> valid_out[1] held with stable data/last. ready_in=0 while obuf full. Resumes with no loss or duplication.
- dst_en changes from all-ones to 8'b0000_0001 after beat 2 of a 5-beat packet to port 3 -> remaining beats still go to port 3. Next packet goes to port 0.
- dst_en=0 with in_pkt=0 and valid_in=1 for 3 cycles -> ready_in=0, nothing accepted. Setting dst_en[6]=1 -> the packet goes to port 6.
- rst_n pulsed low asynchronously mid-packet on port 2 with obuf full -> valid_out=0 immediately, busy=0. The next packet goes to port 0.
